// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: the NOP returned on
// errors and reset, the RV32 opcode it is built from, and the fetch FSM states.
package imem_fetch_responder_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_LOAD
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_responder_byte.sv
// Byte-to-word assembler for the program load path. Bytes arrive
// little-endian; the fourth byte completes a word, which is presented
// combinationally on word/word_valid in the same cycle.
module imem_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shreg_q, shreg_d;

  // Shift each new byte in from the top so the oldest byte ends up in lane 0.
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clear) begin
      idx_d = '0;
    end else if (byte_valid) begin
      shreg_d = {byte_in, shreg_q[23:8]};
      idx_d   = idx_q + 2'd1;
    end
  end

  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
  assign word       = {byte_in, shreg_q};

  // Byte index and partial-word storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Memory-side responder for the CPU instruction-fetch port. Serves one fetch
// at a time with WAIT_CYCLES of emulated latency, and accepts a byte-wide
// program load stream while idle.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_instr,
  output logic                rsp_err,
  input  logic                load_en,
  input  logic                load_valid,
  input  logic [7:0]          load_byte,
  output logic [ADDR_WIDTH:0] load_count,
  output logic                load_overflow
);

  localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);

  fetch_state_e            state_q, state_d;
  logic [3:0]              wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_instr_q, rsp_instr_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH:0]     load_count_q, load_count_d;
  logic                    load_overflow_q, load_overflow_d;

  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [31:0]             mem_rdata;
  logic                    addr_bad;
  logic                    load_full;
  logic                    asm_clear;
  logic                    asm_take;
  logic                    word_valid;
  logic [31:0]             word;

  // Misaligned, or any bit above the array's word range set: no aliasing.
  assign addr_bad  = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);
  assign load_full = (load_count_q == DEPTH_CNT);
  assign asm_clear = (state_q != ST_LOAD);
  assign asm_take  = (state_q == ST_LOAD) && load_en && load_valid && !load_full;

  // Read the live request address on accept, the latched one while waiting.
  assign rd_addr   = (state_q == ST_IDLE) ? req_addr[ADDR_WIDTH+1:2] : addr_q;
  assign mem_rdata = mem[rd_addr];

  imem_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_take),
    .byte_in    (load_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state and registered-output logic for the fetch/load FSM.
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    addr_d          = addr_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_instr_d     = rsp_instr_q;
    rsp_err_d       = rsp_err_q;
    load_count_d    = load_count_q;
    load_overflow_d = load_overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d         = ST_LOAD;
          load_count_d    = '0;
          load_overflow_d = 1'b0;
        end else if (req_valid) begin
          addr_d = req_addr[ADDR_WIDTH+1:2];
          if (addr_bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_instr_d = NOP_INSTR;
            rsp_err_d   = 1'b1;
          end else if (WAIT_INIT == 4'd0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_instr_d = mem_rdata;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      // The word is registered on the cycle the count would reach zero, so
      // rsp_valid rises exactly WAIT_CYCLES cycles after the accept cycle + 1.
      ST_WAIT: begin
        if (wait_q == 4'd1) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_instr_d = mem_rdata;
          rsp_err_d   = 1'b0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (load_valid && load_full) begin
          load_overflow_d = 1'b1;
        end
        if (word_valid) begin
          load_count_d = load_count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wait_q          <= '0;
      addr_q          <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_instr_q     <= NOP_INSTR;
      rsp_err_q       <= 1'b0;
      load_count_q    <= '0;
      load_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      addr_q          <= addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_instr_q     <= rsp_instr_d;
      rsp_err_q       <= rsp_err_d;
      load_count_q    <= load_count_d;
      load_overflow_q <= load_overflow_d;
    end
  end

  // Program store write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem[load_count_q[ADDR_WIDTH-1:0]] <= word;
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !load_en && !reset;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_instr     = rsp_instr_q;
  assign rsp_err       = rsp_err_q;
  assign load_count    = load_count_q;
  assign load_overflow = load_overflow_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: a small-depth instance with two
// wait states, driven by directed and random fetch/load traffic.
module tb_imem_fetch_responder;

  localparam int AW    = 2;
  localparam int WAITS = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        load_en = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic [AW:0] load_count;
  logic        load_overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  exp_t exp_q[$];

  // Reference state: word contents, last session's count and overflow flag.
  logic [31:0] mem_m [DEPTH];
  int          cnt_m = 0;
  logic        ovf_m = 1'b0;

  imem_fetch_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err), .load_en(load_en),
    .load_valid(load_valid), .load_byte(load_byte), .load_count(load_count),
    .load_overflow(load_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a, input int acc);
    exp_t e;
    e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    e.instr = e.err ? NOP : mem_m[int'(a >> 2)];
    e.lat   = e.err ? 0 : WAITS;
    e.acc   = acc;
    return e;
  endfunction

  // Monitor: matches each response against the oldest expectation.
  initial begin : monitor
    bit          in_resp = 0;
    bit          hs = 0;
    int          idle_wait = 0;
    logic [31:0] ci;
    logic        ce;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_resp = 0; hs = 0; idle_wait = 0;
        continue;
      end
      if (hs) begin
        check("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
        in_resp = 0; hs = 0;
        done_cnt++;
      end
      if (in_resp) begin
        check("hold_valid", {31'b0, rsp_valid}, 32'd1);
        check("hold_instr", rsp_instr, ci);
        check("hold_err", {31'b0, rsp_err}, {31'b0, ce});
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("rsp_instr", rsp_instr, e.instr);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          ci = e.instr; ce = e.err;
          in_resp = 1; idle_wait = 0;
        end
      end else if (exp_q.size() > 0) begin
        idle_wait++;
        if (idle_wait > 20) begin
          check("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
          void'(exp_q.pop_front());
          idle_wait = 0;
          done_cnt++;
        end
      end
      if (in_resp || exp_q.size() > 0)
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (in_resp && rsp_ready) hs = 1;
    end
  end

  // stall < 0: random rsp_ready; otherwise hold rsp_ready low for 'stall'
  // cycles of rsp_valid before accepting.
  task automatic do_fetch(input logic [31:0] a, input int stall);
    int start, n, seen;
    @(posedge clk); #1;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    exp_q.push_back(model_fetch(a, cyc));
    start = done_cnt; n = 0; seen = 0;
    while (done_cnt == start && n < 80) begin
      if (stall < 0) rsp_ready = 1'($urandom_range(0, 1));
      else if (stall > 0) begin
        if (rsp_valid) seen++;
        rsp_ready = (seen > stall);
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 80) begin
      check("fetch_done_timeout", 32'(n), 32'd0);
      exp_q.delete();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic do_load(input bq_t b);
    int n, w;
    @(posedge clk); #1;
    load_en = 1'b1;
    @(posedge clk); #1;
    check("req_ready_load", {31'b0, req_ready}, 32'd0);
    foreach (b[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
        @(posedge clk); #1;
      end
      load_valid = 1'b1;
      load_byte  = b[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    @(posedge clk); #1;
    n = b.size();
    w = (n / 4 > DEPTH) ? DEPTH : n / 4;
    for (int i = 0; i < w; i++)
      mem_m[i] = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    cnt_m = w;
    ovf_m = (n > 4 * DEPTH);
    @(negedge clk);
    check("load_count", 32'(load_count), 32'(cnt_m));
    check("load_overflow", {31'b0, load_overflow}, {31'b0, ovf_m});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bq_t b;
    int  r, n;
    logic [31:0] a;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_instr", rsp_instr, NOP);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_load_overflow", {31'b0, load_overflow}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00};
    do_load(b);
    do_fetch(32'h4, 0);
    do_fetch(32'h4, 5);
    do_fetch(32'h0, 0);
    do_fetch(32'h6, 0);
    do_fetch(32'h10, 0);
    do_fetch(32'h8000_0000, 0);

    b.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    do_load(b);
    do_fetch(32'h0, 0);
    do_fetch(32'hC, 0);

    // 4k+3 bytes: the trailing partial word must not reach memory.
    b.delete();
    for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
    do_load(b);
    do_fetch(32'h4, 0);
    do_fetch(32'h0, 0);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        b.delete();
        n = $urandom_range(0, 22);
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        do_load(b);
      end else begin
        case ($urandom_range(0, 3))
          0, 1: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
          2:    a = 32'($urandom_range(0, 4 * DEPTH + 3));
          default: a = $urandom;
        endcase
        do_fetch(a, ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 3));
      end
    end

    // Reset while a fetch is in its wait phase.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    check("midrst_load_count", 32'(load_count), 32'd0);
    check("midrst_rsp_instr", rsp_instr, NOP);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cnt_m = 0;
    ovf_m = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    do_fetch(32'h0, 0);
    do_fetch(32'h8, -1);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
